// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
// Widths here are the defaults; the top can be overridden per build.
package fetch_pkg;

    localparam int A_DEF  = 12;
    localparam int W_DEF  = 9;
    localparam int CW_DEF = 16;

    localparam logic [W_DEF-1:0] HALT_OP = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and enable.
// Clear wins over enable; the count sticks at all ones.
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] count_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != {CW{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/inst_fetch.sv
// PC and run/idle/halt sequencing in front of a combinational ROM.
// Keeps a saturating count of retired instructions.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int A  = A_DEF,
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [W-1:0]  InstIn,
    input  logic          BranchEn,
    input  logic          BranchTaken,
    input  logic          BranchAbs,
    input  logic [A-1:0]  Target,
    output logic [A-1:0]  InstAddress,
    output logic          Running,
    output logic          Halt,
    output logic [CW-1:0] InstCount
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic [A-1:0] pc_q;
    logic [A-1:0] pc_d;
    logic         cnt_clr;
    logic         cnt_en;
    logic         is_halt;
    logic         br_take;

    assign is_halt = (InstIn == {W{1'b1}});
    assign br_take = BranchEn & BranchTaken;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                pc_d = '0;
                if (Start) begin
                    state_d = RUN;
                    cnt_clr = 1'b1;
                end
            end
            RUN: begin
                // Every instruction seen in RUN retires, halt included.
                cnt_en = 1'b1;
                if (is_halt) begin
                    state_d = HALTED;
                end else if (br_take) begin
                    pc_d = BranchAbs ? Target : pc_q + Target;
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            HALTED: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    cnt_clr = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    sat_counter #(
        .CW(CW)
    ) u_count (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .count_o(InstCount)
    );

    assign InstAddress = pc_q;
    assign Running     = (state_q == RUN);
    assign Halt        = (state_q == HALTED);

endmodule
